rv32i_decode_stage: RTL and testbench

Registered RV32I instruction decoder. It sits between instruction fetch (program counter plus instruction memory) and the register file/ALU. It takes a 32-bit fetched instruction and, one clock later, presents the ALU operation, operand-select, memory, branch/jump controls, register indices and the sign-extended immediate. Fully combinational field extraction feeds one output register stage.

---
 rtl/rv32i_decode_stage_if.sv | 31 +++
 rtl/rv32i_decode_stage.sv | 121 ++++++++++++
 tb/tb_rv32i_decode_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_decode_stage_if.sv
// rv32i_decode_stage_if: fetch-to-decode bus carrying the instruction in and decoded controls out
interface rv32i_decode_stage_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        out_valid;
  logic [3:0]  alu_ops;
  logic        alu_src_imm;
  logic        alu_src_pc;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_width;
  logic        mem_unsigned;
  logic        is_branch;
  logic [2:0]  branch_type;
  logic        is_jump;
  logic        is_jalr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_used;
  logic        rs2_used;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        illegal;
  modport master(output instr, instr_valid,
                 input out_valid, alu_ops, alu_src_imm, alu_src_pc, reg_write, mem_read, mem_write, mem_width,
                 mem_unsigned, is_branch, branch_type, is_jump, is_jalr, rs1, rs2, rs1_used, rs2_used, rd, imm, illegal);
  modport slave(input instr, instr_valid,
                output out_valid, alu_ops, alu_src_imm, alu_src_pc, reg_write, mem_read, mem_write, mem_width,
                mem_unsigned, is_branch, branch_type, is_jump, is_jalr, rs1, rs2, rs1_used, rs2_used, rd, imm, illegal);
endinterface

// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: combinational RV32I field decode feeding a single output register stage
module rv32i_decode_stage (
  input logic clk,
  input logic rst_n,
  rv32i_decode_stage_if.slave bus
);
  logic [31:0] w_i;
  logic [6:0]  w_op;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm;
  logic [3:0]  w_alu;
  logic [3:0]  w_alu_f3;
  logic        w_src_imm;
  logic        w_src_pc;
  logic        w_rw;
  logic        w_mr;
  logic        w_mw;
  logic        w_br;
  logic        w_jmp;
  logic        w_jalr;
  logic        w_r1u;
  logic        w_r2u;
  logic        w_ill;
  logic        w_ok;
  assign w_i     = bus.instr;
  assign w_op    = w_i[6:0];
  assign w_f3    = w_i[14:12];
  assign w_f7    = w_i[31:25];
  assign w_imm_i = {{20{w_i[31]}}, w_i[31:20]};
  assign w_imm_s = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
  assign w_imm_b = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
  assign w_imm_u = {w_i[31:12], 12'b0};
  assign w_imm_j = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
  // funct3 to ALU op for the funct7=0000000 flavour of R-type and OP-IMM
  assign w_alu_f3 = w_f3 == 3'b000 ? 4'd0 : w_f3 == 3'b001 ? 4'd2 : w_f3 == 3'b010 ? 4'd3 :
                    w_f3 == 3'b011 ? 4'd4 : w_f3 == 3'b100 ? 4'd5 : w_f3 == 3'b101 ? 4'd6 :
                    w_f3 == 3'b110 ? 4'd8 : 4'd9;
  // a control only leaves the stage for a valid, legal instruction
  assign w_ok = bus.instr_valid & ~w_ill;
  // per-opcode control and immediate selection; illegal encodings keep their decoded immediate
  always_comb begin
    w_alu = 4'd0; w_src_imm = 1'b0; w_src_pc = 1'b0; w_rw = 1'b0; w_mr = 1'b0; w_mw = 1'b0;
    w_br = 1'b0; w_jmp = 1'b0; w_jalr = 1'b0; w_r1u = 1'b0; w_r2u = 1'b0; w_imm = 32'd0; w_ill = 1'b0;
    case (w_op)
      7'b0110011: begin
        w_rw = 1'b1; w_r1u = 1'b1; w_r2u = 1'b1;
        w_alu = w_f7[5] ? (w_f3 == 3'b000 ? 4'd1 : 4'd7) : w_alu_f3;
        w_ill = !(w_f7 == 7'b0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      7'b0010011: begin
        w_rw = 1'b1; w_r1u = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_i;
        w_alu = (w_f3 == 3'b101 && w_f7[5]) ? 4'd7 : w_alu_f3;
        w_ill = (w_f3 == 3'b001 && w_f7 != 7'b0) || (w_f3 == 3'b101 && w_f7 != 7'b0 && w_f7 != 7'b0100000);
      end
      7'b0000011: begin
        w_mr = 1'b1; w_rw = 1'b1; w_r1u = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_i;
        w_ill = w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111;
      end
      7'b0100011: begin
        w_mw = 1'b1; w_r1u = 1'b1; w_r2u = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_s;
        w_ill = w_f3[2] || w_f3 == 3'b011;
      end
      7'b1100011: begin
        w_br = 1'b1; w_alu = 4'd1; w_r1u = 1'b1; w_r2u = 1'b1; w_imm = w_imm_b;
        w_ill = w_f3 == 3'b010 || w_f3 == 3'b011;
      end
      7'b1101111: begin
        w_jmp = 1'b1; w_rw = 1'b1; w_imm = w_imm_j;
      end
      7'b1100111: begin
        w_jmp = 1'b1; w_jalr = 1'b1; w_rw = 1'b1; w_r1u = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_i;
        w_ill = w_f3 != 3'b000;
      end
      7'b0110111: begin
        w_alu = 4'd10; w_src_imm = 1'b1; w_rw = 1'b1; w_imm = w_imm_u;
      end
      7'b0010111: begin
        w_src_pc = 1'b1; w_src_imm = 1'b1; w_rw = 1'b1; w_imm = w_imm_u;
      end
      7'b0001111, 7'b1110011: w_imm = w_imm_i;
      default: w_ill = 1'b1;
    endcase
  end
  // output register: raw fields always load, controls gated by validity and legality
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0; bus.alu_ops <= 4'd0; bus.alu_src_imm <= 1'b0; bus.alu_src_pc <= 1'b0;
      bus.reg_write <= 1'b0; bus.mem_read <= 1'b0; bus.mem_write <= 1'b0; bus.mem_width <= 2'b00;
      bus.mem_unsigned <= 1'b0; bus.is_branch <= 1'b0; bus.branch_type <= 3'b000; bus.is_jump <= 1'b0;
      bus.is_jalr <= 1'b0; bus.rs1 <= 5'd0; bus.rs2 <= 5'd0; bus.rs1_used <= 1'b0; bus.rs2_used <= 1'b0;
      bus.rd <= 5'd0; bus.imm <= 32'd0; bus.illegal <= 1'b0;
    end else begin
      bus.out_valid    <= bus.instr_valid;
      bus.alu_ops      <= w_ok ? w_alu : 4'd0;
      bus.alu_src_imm  <= w_ok & w_src_imm;
      bus.alu_src_pc   <= w_ok & w_src_pc;
      bus.reg_write    <= w_ok & w_rw & (w_i[11:7] != 5'd0);
      bus.mem_read     <= w_ok & w_mr;
      bus.mem_write    <= w_ok & w_mw;
      bus.mem_width    <= (w_ok & (w_mr | w_mw)) ? w_f3[1:0] : 2'b00;
      bus.mem_unsigned <= w_ok & w_mr & w_f3[2];
      bus.is_branch    <= w_ok & w_br;
      bus.branch_type  <= (w_ok & w_br) ? w_f3 : 3'b000;
      bus.is_jump      <= w_ok & w_jmp;
      bus.is_jalr      <= w_ok & w_jalr;
      bus.rs1          <= w_i[19:15];
      bus.rs2          <= w_i[24:20];
      bus.rs1_used     <= w_ok & w_r1u;
      bus.rs2_used     <= w_ok & w_r2u;
      bus.rd           <= w_i[11:7];
      bus.imm          <= w_imm;
      bus.illegal      <= bus.instr_valid & w_ill;
    end
  end
endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb_rv32i_decode_stage: scoreboard-driven bench for the registered RV32I decoder
module tb_rv32i_decode_stage;
  typedef struct packed {
    logic        v;
    logic [3:0]  alu;
    logic        si;
    logic        sp;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  w;
    logic        u;
    logic        br;
    logic [2:0]  bt;
    logic        j;
    logic        jr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        r1u;
    logic        r2u;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } out_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  out_t sb[$];
  rv32i_decode_stage_if dif();
  rv32i_decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(dif.slave));
  always #5 clk = ~clk;
  function automatic out_t obs();
    return {dif.out_valid, dif.alu_ops, dif.alu_src_imm, dif.alu_src_pc, dif.reg_write, dif.mem_read,
            dif.mem_write, dif.mem_width, dif.mem_unsigned, dif.is_branch, dif.branch_type, dif.is_jump,
            dif.is_jalr, dif.rs1, dif.rs2, dif.rs1_used, dif.rs2_used, dif.rd, dif.imm, dif.illegal};
  endfunction
  function automatic out_t base(input logic [31:0] ins, input logic v);
    out_t e = '0;
    e.v = v; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    return e;
  endfunction
  function automatic out_t ctl(input out_t o);
    out_t c = o;
    c.rs1 = '0; c.rs2 = '0; c.rd = '0; c.imm = '0;
    return c;
  endfunction
  task automatic drive(input logic [31:0] ins, input logic v, input out_t e);
    @(negedge clk);
    dif.instr = ins;
    dif.instr_valid = v;
    sb.push_back(e);
  endtask
  task automatic test_reset();
    out_t e;
    out_t o;
    dif.instr = 32'h00500093;
    dif.instr_valid = 1'b1;
    sb.push_back('0);
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_hold: got %h expected %h", o, e); end
    @(negedge clk);
    rst_n = 1'b1;
    e = base(32'h00500093, 1'b1); e.si = 1; e.rw = 1; e.r1u = 1; e.imm = 32'd5;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL addi_after_reset: got %h expected %h", o, e); end
  endtask
  task automatic test_alu_store();
    out_t e;
    out_t o;
    e = base(32'h402081B3, 1'b1); e.alu = 4'd1; e.rw = 1; e.r1u = 1; e.r2u = 1;
    drive(32'h402081B3, 1'b1, e);
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL sub: got %h expected %h", o, e); end
    e = base(32'h0020A423, 1'b1); e.mw = 1; e.w = 2'b10; e.si = 1; e.r1u = 1; e.r2u = 1; e.imm = 32'd8;
    drive(32'h0020A423, 1'b1, e);
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL sw: got %h expected %h", o, e); end
  endtask
  task automatic test_branch_lui();
    out_t e;
    out_t o;
    e = base(32'hFE208EE3, 1'b1); e.br = 1; e.alu = 4'd1; e.r1u = 1; e.r2u = 1; e.imm = 32'hFFFFFFFC;
    drive(32'hFE208EE3, 1'b1, e);
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL beq: got %h expected %h", o, e); end
    e = base(32'h123452B7, 1'b1); e.alu = 4'd10; e.si = 1; e.rw = 1; e.imm = 32'h12345000;
    drive(32'h123452B7, 1'b1, e);
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL lui: got %h expected %h", o, e); end
  endtask
  task automatic test_illegal_x0();
    out_t e;
    out_t o;
    e = base(32'hFFFFFFFF, 1'b1); e.ill = 1;
    drive(32'hFFFFFFFF, 1'b1, e);
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); o.imm = '0; checks++;
    if (o !== e) begin errors++; $display("FAIL illegal_ones: got %h expected %h", o, e); end
    e = base(32'h00000013, 1'b1); e.si = 1; e.r1u = 1;
    drive(32'h00000013, 1'b1, e);
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL addi_x0: got %h expected %h", o, e); end
  endtask
  task automatic test_invalid_async();
    out_t e;
    out_t o;
    drive(32'h00500093, 1'b0, base(32'h00500093, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (ctl(o) !== ctl(e)) begin errors++; $display("FAIL invalid_gated: got %h expected %h", ctl(o), ctl(e)); end
    e = base(32'h00500093, 1'b1); e.si = 1; e.rw = 1; e.r1u = 1; e.imm = 32'd5;
    drive(32'h00500093, 1'b1, e);
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL pre_async: got %h expected %h", o, e); end
    #2 rst_n = 1'b0;
    #1;
    o = obs(); checks++;
    if (o !== out_t'('0)) begin errors++; $display("FAIL async_reset: got %h expected %h", o, out_t'('0)); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_back_to_back();
    logic [31:0] ins[11];
    out_t ex[11];
    out_t e;
    out_t o;
    ins[0] = 32'h0040C303; ex[0] = base(ins[0], 1); ex[0].mr = 1; ex[0].u = 1; ex[0].rw = 1; ex[0].r1u = 1; ex[0].si = 1; ex[0].imm = 32'd4;
    ins[1] = 32'hFFE11383; ex[1] = base(ins[1], 1); ex[1].mr = 1; ex[1].w = 2'b01; ex[1].rw = 1; ex[1].r1u = 1; ex[1].si = 1; ex[1].imm = 32'hFFFFFFFE;
    ins[2] = 32'h008000EF; ex[2] = base(ins[2], 1); ex[2].j = 1; ex[2].rw = 1; ex[2].imm = 32'd8;
    ins[3] = 32'h00008067; ex[3] = base(ins[3], 1); ex[3].j = 1; ex[3].jr = 1; ex[3].r1u = 1; ex[3].si = 1;
    ins[4] = 32'h00001217; ex[4] = base(ins[4], 1); ex[4].sp = 1; ex[4].si = 1; ex[4].rw = 1; ex[4].imm = 32'h00001000;
    ins[5] = 32'h4032D293; ex[5] = base(ins[5], 1); ex[5].alu = 4'd7; ex[5].si = 1; ex[5].rw = 1; ex[5].r1u = 1; ex[5].imm = 32'h00000403;
    ins[6] = 32'h40129293; ex[6] = base(ins[6], 1); ex[6].ill = 1; ex[6].imm = 32'h00000401;
    ins[7] = 32'h0020A063; ex[7] = base(ins[7], 1); ex[7].ill = 1;
    ins[8] = 32'h0000000F; ex[8] = base(ins[8], 1);
    ins[9] = 32'h00000073; ex[9] = base(ins[9], 1);
    ins[10] = 32'h00C5F533; ex[10] = base(ins[10], 1); ex[10].alu = 4'd9; ex[10].rw = 1; ex[10].r1u = 1; ex[10].r2u = 1;
    for (int i = 0; i < 11; i++) begin
      drive(ins[i], 1'b1, ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b[%0d] %h: got %h expected %h", i, ins[i], o, e); end
    end
  endtask
  initial begin
    dif.instr = 32'd0;
    dif.instr_valid = 1'b0;
    test_reset();
    test_alu_store();
    test_branch_lui();
    test_illegal_x0();
    test_invalid_async();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
